// File: rtl/bitwise_pkg.sv
// Shared types and constants for the registered bitwise logic stage.
package bitwise_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_NAND = 2'b01,
        OP_NOR  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

endpackage

// File: rtl/bitwise_gate_bank.sv
// Combinational per-bit gate bank producing AND, NAND and NOR vectors of two operands.
module bitwise_gate_bank #(
    parameter int WIDTH = bitwise_pkg::WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] and_vec,
    output logic [WIDTH-1:0] nand_vec,
    output logic [WIDTH-1:0] nor_vec
);

    // Each bit is independent: no carries or cross-bit terms.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign and_vec[i]  = a[i] & b[i];
        assign nand_vec[i] = ~(a[i] & b[i]);
        assign nor_vec[i]  = ~(a[i] | b[i]);
    end

endmodule

// File: rtl/bitwise_nand_nor_unit.sv
// Single-cycle registered AND/NAND/NOR stage with zero, all-ones and reserved-op status.
module bitwise_nand_nor_unit
    import bitwise_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             all_ones,
    output logic             op_err
);

    // Handshake: in_valid qualifies a/b/op at a rising edge; out_valid is high for
    // exactly the cycle after each such edge. There is no ready, so nothing stalls.
    logic [WIDTH-1:0] and_vec;
    logic [WIDTH-1:0] nand_vec;
    logic [WIDTH-1:0] nor_vec;
    logic [WIDTH-1:0] result;
    logic             result_err;
    logic             result_zero;
    logic             result_ones;

    bitwise_gate_bank #(.WIDTH(WIDTH)) u_gate_bank (
        .a        (a),
        .b        (b),
        .and_vec  (and_vec),
        .nand_vec (nand_vec),
        .nor_vec  (nor_vec)
    );

    always_comb begin
        result     = '0;
        result_err = 1'b0;
        case (op_e'(op))
            OP_AND:  result = and_vec;
            OP_NAND: result = nand_vec;
            OP_NOR:  result = nor_vec;
            default: result_err = 1'b1;
        endcase
    end

    // Reserved op yields a zero result, so the flags fall out naturally.
    assign result_zero = (result == '0);
    assign result_ones = (result == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b0;
            all_ones  <= 1'b0;
            op_err    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out      <= result;
                zero     <= result_zero;
                all_ones <= result_ones;
                op_err   <= result_err;
            end
        end
    end

endmodule

// File: tb/tb_bitwise_nand_nor_unit.sv
// Randomized scoreboard bench for bitwise_nand_nor_unit against a behavioural model.
module tb_bitwise_nand_nor_unit;

    localparam int WIDTH = 32;
    localparam int EW    = WIDTH + 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [1:0]       op = 2'b00;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             all_ones;
    logic             op_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected entries packed as {result, zero, all_ones, op_err}.
    logic [EW-1:0]    exp_q[$];
    logic [WIDTH-1:0] held_out;
    logic             held_zero;
    logic             held_ones;
    logic             held_err;

    bitwise_nand_nor_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out       (out),
        .zero      (zero),
        .all_ones  (all_ones),
        .op_err    (op_err)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bit-by-bit truth table evaluation.
    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                            input logic [1:0] f);
        logic [WIDTH-1:0] r;
        int ones;
        r = '0;
        ones = 0;
        for (int i = 0; i < WIDTH; i++) begin
            int s;
            s = int'(x[i]) + int'(y[i]);
            case (f)
                2'd0: r[i] = (s == 2);
                2'd1: r[i] = (s != 2);
                2'd2: r[i] = (s == 0);
                default: r[i] = 1'b0;
            endcase
            ones += int'(r[i]);
        end
        return {r, ones == 0, ones == WIDTH, f == 2'd3};
    endfunction

    // Driver tasks: inputs change 1 time unit after a rising edge.
    task automatic drive(input logic v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic [1:0] f);
        in_valid = v;
        a = x;
        b = y;
        op = f;
        @(posedge clk);
        if (v && rst_n) exp_q.push_back(model(x, y, f));
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        exp_q.delete();
        held_out = '0;
        held_zero = 1'b0;
        held_ones = 1'b0;
        held_err = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, '0);
        check("async_rst_out", out, '0);
        check("async_rst_flags", {29'd0, zero, all_ones, op_err}, '0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", {31'd0, out_valid}, '0);
            check("rst_out", out, '0);
            check("rst_flags", {29'd0, zero, all_ones, op_err}, '0);
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got out_valid=1 expected out_valid=0 at %0t", $time);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("out", out, e[EW-1:3]);
                check("zero", {31'd0, zero}, {31'd0, e[2]});
                check("all_ones", {31'd0, all_ones}, {31'd0, e[1]});
                check("op_err", {31'd0, op_err}, {31'd0, e[0]});
                held_out = e[EW-1:3];
                held_zero = e[2];
                held_ones = e[1];
                held_err = e[0];
            end
        end else begin
            check("missing_valid", exp_q.size(), 0);
            check("held_out", out, held_out);
            check("held_flags", {29'd0, zero, all_ones, op_err},
                  {29'd0, held_zero, held_ones, held_err});
        end
    end

    initial begin
        // Reset held with live-looking inputs; clear must precede the first clk edge.
        in_valid = 1'b1;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        op = 2'b01;
        #2;
        apply_reset();
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        release_reset();

        // Directed cases
        drive(1'b1, 32'hF0F0_F0F0, 32'hAAAA_AAAA, 2'b00);
        drive(1'b1, 32'hCCCC_CCCC, 32'h3333_3333, 2'b01);
        drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01);
        drive(1'b1, 32'hCCCC_CCCC, 32'h3333_3333, 2'b10);
        drive(1'b1, 32'h0000_0000, 32'h0000_0000, 2'b10);
        drive(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 2'b11);
        drive(1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, 2'b00);
        drive(1'b1, 32'h0000_FFFF, 32'h00FF_00FF, 2'b10);
        drive(1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b01);
        drive(1'b0, 32'h0, 32'h0, 2'b10);

        // Mid-stream reset: captured result must never appear.
        drive(1'b1, 32'hFFFF_FFFF, 32'h0F0F_0000, 2'b00);
        apply_reset();
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        release_reset();
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        drive(1'b1, 32'hAAAA_5555, 32'h5555_AAAA, 2'b01);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            logic [WIDTH-1:0] x;
            logic [WIDTH-1:0] y;
            x = $urandom();
            y = $urandom();
            case ($urandom_range(0, 7))
                0: x = '0;
                1: y = '1;
                2: y = ~x;
                3: y = x;
                default: ;
            endcase
            drive($urandom_range(0, 3) != 0, x, y, 2'($urandom_range(0, 3)));
        end
        drive(1'b0, 32'h0, 32'h0, 2'b00);
        drive(1'b0, 32'h0, 32'h0, 2'b00);

        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bitwise_nand_nor_unit.md
Name: bitwise_nand_nor_unit

Overview:
- Registered 32-bit bitwise logic stage. It computes AND, NAND or NOR of two operands, selected per transaction.
- Sits in the ALU logical path as a single-cycle pipelined slice behind operand fetch.
- Produces a result plus zero/all-ones status flags, with a valid strobe.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 1.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op are valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  function select: 00 AND, 01 NAND, 10 NOR, 11 reserved.
- out_valid  output  1  registered result valid.
- out  output  WIDTH  registered result.
- zero  output  1  out == 0 (registered with out).
- all_ones  output  1  out == all ones (registered with out).
- op_err  output  1  captured op was reserved (11).

Behaviour:
- Reset: one clock; asynchronous, active-low reset named rst_n, clock named clk. rst_n low forces out=0, out_valid=0, zero=0, all_ones=0, op_err=0 immediately, without waiting for a clock edge.
- Deassertion of rst_n is synchronous to clk, handled by the system reset synchroniser.
- Latency is exactly 1 cycle. A rising edge with in_valid=1 captures the result: out, flags and op_err, and sets out_valid=1.
- A rising edge with in_valid=0 clears out_valid to 0. out, zero, all_ones and op_err hold their previous values.
- Function, bitwise per bit i:
  - AND: out[i] = a[i] & b[i].
  - NAND: out[i] = ~(a[i] & b[i]).
  - NOR: out[i] = ~(a[i] | b[i]).
- Reserved op 11: out=0, zero=1, all_ones=0, op_err=1. out_valid still asserts, so the error is reported and not dropped.
- For legal ops, op_err=0.
- Flags:
  - zero = (result == 0) and all_ones = (result == {WIDTH{1}}), both computed on the combinational result before the register.
  - zero and all_ones are never both 1 for WIDTH >= 1.
- No backpressure: every valid input produces exactly one output one cycle later. Back-to-back valid inputs produce back-to-back outputs.
- If reset asserts mid-stream, the in-flight result is discarded. The first post-reset out_valid needs a new in_valid.
- The operation is purely combinational between the input and output registers. There are no carries and no cross-bit dependence.

Decomposition:
- Shared package bitwise_pkg:
  - typedef for the 2-bit op enum: OP_AND=2'b00, OP_NAND=2'b01, OP_NOR=2'b10, OP_RSVD=2'b11.
  - WIDTH default constant.
- One sub-module, bitwise_gate_bank (combinational):
  - Takes a, b.
  - Emits the and/nand/nor vectors built per-bit via generate.
- The top level does the op mux, flag compute and output registers.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, a=FFFFFFFF, b=FFFFFFFF -> out=0, out_valid=0, all flags 0. The clear happens asynchronously, before any clk edge.
- AND: a=F0F0F0F0, b=AAAAAAAA, op=00 -> next cycle out=A0A0A0A0, zero=0, all_ones=0, out_valid=1.
- NAND: a=CCCCCCCC, b=33333333, op=01 -> out=FFFFFFFF, all_ones=1, zero=0. Also a=FFFFFFFF, b=FFFFFFFF -> out=00000000, zero=1.
- NOR: a=CCCCCCCC, b=33333333, op=10 -> out=00000000, zero=1. Also a=0, b=0 -> out=FFFFFFFF, all_ones=1.
- Reserved/pipeline:
  - op=11 with any operands -> out=0, zero=1, op_err=1, out_valid=1.
  - Back-to-back AND then NOR over consecutive cycles yields both results on consecutive cycles.
  - in_valid=0 afterwards -> out_valid=0 with out held.
- Mid-stream reset: assert rst_n=0 between two valid inputs -> outputs clear at once, and no stale out_valid appears after release.
